// File: rtl/jtpang_bank_arb.sv
// Pang SDRAM bank arbiter: refresh > ROM download > round-robin bank reads,
// one command at a time on a req/gnt PHY port with fixed-length read bursts.

module jtpang_bank_arb_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic gnt,
  input  logic dv,
  input  logic first,
  input  logic last,
  output logic ack,
  output logic dst,
  output logic dok,
  output logic rdy
);
  logic ack_d, dst_d, dok_d, rdy_d;
  logic ack_q, dst_q, dok_q, rdy_q;

  always_comb begin
    ack_d = gnt;
    dok_d = dv;
    dst_d = dv & first;
    rdy_d = dv & last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {ack_q, dst_q, dok_q, rdy_q} <= '0;
    else        {ack_q, dst_q, dok_q, rdy_q} <= {ack_d, dst_d, dok_d, rdy_d};
  end

  assign ack = ack_q;
  assign dst = dst_q;
  assign dok = dok_q;
  assign rdy = rdy_q;
endmodule

module jtpang_bank_arb #(
  parameter int REF_CYCLES = 384,
  parameter int BURST      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic [3:0]  ba_rd,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_dok,
  output logic [3:0]  ba_rdy,
  output logic [15:0] data_read,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  input  logic        prog_rd,
  output logic        prog_ack,
  output logic        prog_rdy,
  output logic        phy_req,
  output logic        phy_ref,
  output logic        phy_wr,
  output logic [1:0]  phy_ba,
  output logic [21:0] phy_addr,
  output logic [15:0] phy_din,
  output logic [1:0]  phy_mask,
  input  logic        phy_gnt,
  input  logic        phy_dv,
  input  logic [15:0] phy_dout
);
  localparam int              NUM_BANKS = 4;
  localparam int              RW        = $clog2(REF_CYCLES);
  localparam logic [RW-1:0]   REF_LAST  = RW'(REF_CYCLES - 1);
  localparam logic [1:0]      LAST_BEAT = 2'(BURST - 1);
  localparam logic [1:0]      S_IDLE = 2'd0, S_CMD = 2'd1, S_DATA = 2'd2;

  typedef struct packed {
    logic        rf;
    logic        wr;
    logic        prog;
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  mask;
  } cmd_t;

  logic [NUM_BANKS-1:0][21:0] ba_addr;
  assign ba_addr = {ba3_addr, ba2_addr, ba1_addr, ba0_addr};

  logic [1:0]    st_q, st_d, rr_q, rr_d, beat_q, beat_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d, req_q, req_d;
  logic          prog_ack_q, prog_ack_d, prog_rdy_q, prog_rdy_d;
  logic [15:0]   data_q, data_d;
  cmd_t          cmd_q, cmd_d;

  logic       bank_hit, gnt_ev, dv_ev, last_beat, bank_op;
  logic [1:0] bank_sel, cand;

  // Round-robin search starts one past the last served bank
  always_comb begin
    bank_hit = 1'b0;
    bank_sel = rr_q;
    cand     = rr_q;
    for (int k = 1; k <= NUM_BANKS; k++) begin
      cand = rr_q + 2'(k);
      if (!bank_hit && ba_rd[cand]) begin
        bank_hit = 1'b1;
        bank_sel = cand;
      end
    end
  end

  assign last_beat = cmd_q.wr | (beat_q == LAST_BEAT);
  assign bank_op   = ~cmd_q.rf & ~cmd_q.prog;

  always_comb begin
    st_d       = st_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    cmd_d      = cmd_q;
    req_d      = req_q;
    data_d     = data_q;
    ref_pend_d = ref_pend_q;
    prog_ack_d = 1'b0;
    prog_rdy_d = 1'b0;
    gnt_ev     = 1'b0;
    dv_ev      = 1'b0;
    ref_cnt_d  = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + 1'b1;
    case (st_q)
      S_IDLE: begin
        beat_d = 2'd0;
        if (ref_pend_q) begin
          cmd_d      = '0;
          cmd_d.rf   = 1'b1;
          st_d       = S_CMD;
          req_d      = 1'b1;
        end else if (prog_we | prog_rd) begin
          cmd_d.rf   = 1'b0;
          cmd_d.wr   = prog_we;
          cmd_d.prog = 1'b1;
          cmd_d.ba   = prog_ba;
          cmd_d.addr = prog_addr;
          cmd_d.din  = prog_data;
          cmd_d.mask = prog_mask;
          st_d       = S_CMD;
          req_d      = 1'b1;
        end else if (!downloading && bank_hit) begin
          cmd_d      = '0;
          cmd_d.ba   = bank_sel;
          cmd_d.addr = ba_addr[bank_sel];
          rr_d       = bank_sel;
          st_d       = S_CMD;
          req_d      = 1'b1;
        end
      end
      S_CMD: begin
        if (phy_gnt) begin
          gnt_ev     = 1'b1;
          req_d      = 1'b0;
          prog_ack_d = cmd_q.prog;
          if (cmd_q.rf) begin
            ref_pend_d = 1'b0;
            st_d       = S_IDLE;
          end else begin
            st_d       = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (phy_dv) begin
          dv_ev      = 1'b1;
          beat_d     = beat_q + 2'd1;
          prog_rdy_d = cmd_q.prog & last_beat;
          if (!cmd_q.wr) data_d = phy_dout;
          if (last_beat) st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
    // A wrap coinciding with the refresh grant starts a fresh interval
    if (ref_cnt_q == REF_LAST) ref_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      rr_q       <= 2'd3;
      beat_q     <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      req_q      <= 1'b0;
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      data_q     <= '0;
      cmd_q      <= '0;
    end else begin
      st_q       <= st_d;
      rr_q       <= rr_d;
      beat_q     <= beat_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      req_q      <= req_d;
      prog_ack_q <= prog_ack_d;
      prog_rdy_q <= prog_rdy_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
    logic sel;
    assign sel = bank_op & (cmd_q.ba == 2'(i));
    jtpang_bank_arb_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .gnt   (gnt_ev & sel),
      .dv    (dv_ev & sel),
      .first (beat_q == 2'd0),
      .last  (last_beat),
      .ack   (ba_ack[i]),
      .dst   (ba_dst[i]),
      .dok   (ba_dok[i]),
      .rdy   (ba_rdy[i])
    );
  end

  assign data_read = data_q;
  assign prog_ack  = prog_ack_q;
  assign prog_rdy  = prog_rdy_q;
  assign phy_req   = req_q;
  assign phy_ref   = cmd_q.rf;
  assign phy_wr    = cmd_q.wr;
  assign phy_ba    = cmd_q.ba;
  assign phy_addr  = cmd_q.addr;
  assign phy_din   = cmd_q.din;
  assign phy_mask  = cmd_q.mask;
endmodule

// File: tb/tb_jtpang_bank_arb.sv
// Bench for jtpang_bank_arb: scripted PHY responder plus a transaction-level
// model of refresh timing, priority and round-robin order.

module tb_jtpang_bank_arb;
  localparam int REF = 16, BURST = 2;
  localparam int K_NONE = 0, K_REF = 1, K_PROG = 2, K_BANK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        downloading;
  logic [21:0] a [4];
  logic [3:0]  ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read, prog_data, phy_din, phy_dout;
  logic [21:0] prog_addr, phy_addr;
  logic [1:0]  prog_mask, prog_ba, phy_ba, phy_mask;
  logic        prog_we, prog_rd, prog_ack, prog_rdy;
  logic        phy_req, phy_ref, phy_wr, phy_gnt, phy_dv;

  jtpang_bank_arb #(.REF_CYCLES(REF), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ba0_addr(a[0]), .ba1_addr(a[1]), .ba2_addr(a[2]), .ba3_addr(a[3]),
    .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy), .phy_req(phy_req), .phy_ref(phy_ref),
    .phy_wr(phy_wr), .phy_ba(phy_ba), .phy_addr(phy_addr), .phy_din(phy_din),
    .phy_mask(phy_mask), .phy_gnt(phy_gnt), .phy_dv(phy_dv), .phy_dout(phy_dout)
  );

  int checks = 0, errors = 0;
  int m_cnt, m_rr;
  bit m_pend, arb_pend, cur_ref, req_prev, rose;
  bit s_pend, s_we, s_rd, s_dl;
  logic [3:0]  s_ba_rd;
  logic [21:0] s_paddr;
  logic [15:0] s_pdata;
  logic [1:0]  s_pmask, s_pba;
  logic [15:0] dvq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
             phy_req, phy_ref, phy_wr, phy_ba, phy_addr, phy_din, phy_mask};
  endfunction

  task automatic mreset();
    m_cnt = 0; m_pend = 0; m_rr = 3; req_prev = 0; cur_ref = 0;
  endtask

  // One clock edge; the refresh model advances with it and any new request is
  // snapshotted together with the inputs the arbiter saw at that edge.
  task automatic tick();
    @(posedge clk);
    arb_pend = m_pend;
    if (rst_n) begin
      if (phy_gnt && cur_ref) m_pend = 0;
      if (m_cnt == REF - 1) begin m_cnt = 0; m_pend = 1; end
      else m_cnt++;
    end
    #1;
    rose = phy_req && !req_prev;
    if (rose) begin
      s_pend = arb_pend; s_we = prog_we; s_rd = prog_rd; s_dl = downloading;
      s_ba_rd = ba_rd; s_paddr = prog_addr; s_pdata = prog_data;
      s_pmask = prog_mask; s_pba = prog_ba;
    end
    req_prev = phy_req;
  endtask

  task automatic run_op(input int gdly, input int abort_at, output int kind, output int b);
    int n, nb;
    logic [15:0] v;
    logic [21:0] e_addr;
    logic [1:0]  e_ba;
    logic        e_wr;
    logic [3:0]  oh;
    kind = K_NONE; b = 0; n = 0;
    e_wr = 0; e_ba = 0; e_addr = 0;
    while (!phy_req && n < 60) begin tick(); n++; end
    if (!phy_req) begin chk("req_timeout", 0, 1); return; end
    if (s_pend) kind = K_REF;
    else if (s_we || s_rd) begin
      kind = K_PROG; e_wr = s_we; e_ba = s_pba; e_addr = s_paddr;
    end else if (!s_dl && s_ba_rd != 0) begin
      kind = K_BANK;
      for (int k = 1; k <= 4; k++) begin
        b = (m_rr + k) % 4;
        if (s_ba_rd[b]) break;
      end
      m_rr = b; e_ba = 2'(b); e_addr = a[b];
    end
    chk("cmd_expected", kind != K_NONE, 1);
    cur_ref = (kind == K_REF);
    chk("phy_ref", phy_ref, cur_ref);
    if (kind != K_REF) begin
      chk("phy_wr", phy_wr, e_wr);
      chk("phy_ba", phy_ba, e_ba);
      chk("phy_addr", phy_addr, e_addr);
    end
    if (kind == K_PROG && s_we) begin
      chk("phy_din", phy_din, s_pdata);
      chk("phy_mask", phy_mask, s_pmask);
    end
    repeat (gdly) begin
      tick();
      chk("req_hold", phy_req, 1);
      if (kind != K_REF) chk("addr_hold", phy_addr, e_addr);
    end
    phy_gnt = 1; tick(); phy_gnt = 0; cur_ref = 0;
    oh = (kind == K_BANK) ? 4'(1 << b) : 4'd0;
    chk("ba_ack", ba_ack, oh);
    chk("prog_ack", prog_ack, kind == K_PROG);
    chk("req_drop", phy_req, 0);
    if (kind == K_BANK) ba_rd[b] = 1'b0;
    if (kind == K_PROG) begin prog_we = 0; prog_rd = 0; end
    if (kind != K_PROG && kind != K_BANK) return;
    nb = (kind == K_PROG && s_we) ? 1 : BURST;
    for (int k = 0; k < nb; k++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("gap_strobe", {ba_dok, ba_dst, ba_rdy, prog_rdy}, 0);
      end
      if (k == abort_at) begin
        rst_n = 0; #1;
        chk("rst_outs", any_out(), 0);
        return;
      end
      v = (dvq.size() != 0) ? dvq.pop_front() : 16'($urandom);
      phy_dv = 1; phy_dout = v; tick(); phy_dv = 0;
      if (kind == K_BANK) begin
        chk("ba_dok", ba_dok, oh);
        chk("ba_dst", ba_dst, (k == 0) ? oh : 4'd0);
        chk("ba_rdy", ba_rdy, (k == nb - 1) ? oh : 4'd0);
        chk("data_read", data_read, v);
        chk("prog_rdy_bank", prog_rdy, 0);
      end else begin
        chk("ba_dok_prog", ba_dok, 0);
        chk("prog_rdy", prog_rdy, k == nb - 1);
        if (!s_we) chk("prog_data_read", data_read, v);
      end
    end
  endtask

  task automatic serve(input int gdly, output int kind, output int b);
    for (int t = 0; t < 4; t++) begin
      run_op(gdly, -1, kind, b);
      if (kind != K_REF) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int kind, b, nref;
    logic [15:0] d;
    downloading = 0; ba_rd = 0; prog_we = 0; prog_rd = 0;
    prog_addr = 0; prog_data = 0; prog_mask = 0; prog_ba = 0;
    phy_gnt = 0; phy_dv = 0; phy_dout = 0;
    for (int j = 0; j < 4; j++) a[j] = 22'(16'h100 * (j + 1));
    #12;
    chk("reset_outs", any_out(), 0);
    mreset();
    ba_rd = 4'hF;
    rst_n = 1;
    tick();
    chk("req_at_n_plus_1", phy_req, 1);

    // Round robin from reset pointer
    for (int i = 0; i < 5; i++) begin
      serve(1, kind, b);
      chk("rr_order", b, i % 4);
      ba_rd[b] = 1'b1;
    end

    // Single read with known data
    ba_rd = 4'b0100; a[2] = 22'h1234;
    dvq.push_back(16'hAAAA); dvq.push_back(16'h5555);
    serve(3, kind, b);
    chk("single_kind", kind, K_BANK);
    chk("single_bank", b, 2);

    // Refresh preempts continuous bank traffic
    ba_rd = 4'hF; nref = 0;
    for (int i = 0; i < 8; i++) begin
      run_op(0, -1, kind, b);
      if (kind == K_REF) nref++;
      else if (kind == K_BANK) ba_rd[b] = 1'b1;
    end
    chk("saw_refresh", nref > 0, 1);

    // Download write blocks bank reads until downloading drops
    downloading = 1; ba_rd = 4'b0001;
    prog_we = 1; prog_addr = 22'h3_0000; prog_data = 16'hBEEF; prog_mask = 2'b01; prog_ba = 2'd1;
    serve(2, kind, b);
    chk("dl_kind", kind, K_PROG);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dl_no_ack", ba_ack, 0);
      if (phy_req) break;
    end
    downloading = 0;
    serve(2, kind, b);
    chk("dl_bank_kind", kind, K_BANK);
    chk("dl_bank0", b, 0);

    // Stray dv with nothing in flight
    ba_rd = 0; d = data_read;
    phy_dv = 1; phy_dout = 16'hDEAD; tick(); phy_dv = 0;
    chk("stray_strobe", {ba_dok, ba_dst, ba_rdy, prog_rdy}, 0);
    chk("stray_data", data_read, d);
    if (phy_req) run_op(0, -1, kind, b);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      downloading = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 4; j++) a[j] = 22'($urandom);
      ba_rd = ba_rd | 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        prog_we = 1'($urandom_range(0, 1)); prog_rd = !prog_we;
        prog_addr = 22'($urandom); prog_data = 16'($urandom);
        prog_mask = 2'($urandom); prog_ba = 2'($urandom);
      end
      run_op($urandom_range(0, 3), -1, kind, b);
    end

    // Reset in the middle of a burst
    downloading = 0; prog_we = 0; prog_rd = 0; ba_rd = 4'b0010;
    for (int t = 0; t < 4; t++) begin
      run_op(1, 1, kind, b);
      if (kind != K_REF) break;
    end
    chk("abort_kind", kind, K_BANK);
    repeat (2) tick();
    chk("rst_hold_outs", any_out(), 0);
    ba_rd = 4'b1001;
    rst_n = 1; mreset();
    phy_dv = 1; phy_dout = 16'h1111; tick(); phy_dv = 0;
    chk("post_rst_rdy", {ba_rdy, ba_dok, ba_dst}, 0);
    serve(1, kind, b);
    chk("post_rst_rr", b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
